// File: rtl/led_pattern_gen.sv
// LED animation engine: static patterns, blink, running light and bouncing light,
// stepped by a prescaled base tick with a 2^speed step divider.
module led_pattern_gen #(
    parameter int unsigned       LED_W   = 10,
    parameter int unsigned       CLK_DIV = 12_500_000,
    parameter logic [LED_W-1:0]  PAT_A   = 10'b1001010111,
    parameter logic [LED_W-1:0]  PAT_B   = 10'b0110101000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             sel_i,
    input  logic [1:0]       speed_i,
    output logic [LED_W-1:0] led_o,
    output logic             tick_o
);

    localparam int unsigned   PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [LED_W-1:0] ONE_HOT0 = {{(LED_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        M_STATIC = 2'd0,
        M_BLINK  = 2'd1,
        M_RUN    = 2'd2,
        M_BOUNCE = 2'd3
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [2:0]       step_q, step_d;
    logic             dir_up_q, dir_up_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             tick_q, tick_d;

    logic             mode_chg;
    logic             base_tick;
    logic             step_evt;
    logic [2:0]       step_thr;
    logic [LED_W-1:0] sel_pat;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= M_STATIC;
            presc_q  <= '0;
            step_q   <= '0;
            dir_up_q <= 1'b1;
            led_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
            dir_up_q <= dir_up_d;
            led_q    <= led_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        mode_d   = mode_e'(mode_i);
        presc_d  = presc_q;
        step_d   = step_q;
        dir_up_d = dir_up_q;
        led_d    = led_q;
        tick_d   = 1'b0;

        mode_chg  = (mode_e'(mode_i) != mode_q);
        base_tick = en_i && (presc_q == PRESC_MAX);
        step_thr  = 3'((4'd1 << speed_i) - 4'd1);
        // >= rather than == so a speed reduction mid-count steps on the next base tick
        step_evt  = base_tick && (step_q >= step_thr);
        sel_pat   = sel_i ? PAT_A : PAT_B;

        if (mode_chg) begin
            presc_d  = '0;
            step_d   = '0;
            dir_up_d = 1'b1;
            case (mode_e'(mode_i))
                M_STATIC: led_d = sel_pat;
                M_BLINK:  led_d = PAT_A;
                default:  led_d = ONE_HOT0;
            endcase
        end else begin
            if (en_i) begin
                presc_d = base_tick ? '0 : presc_q + 1'b1;
                if (base_tick) begin
                    step_d = step_evt ? '0 : step_q + 1'b1;
                end
            end
            tick_d = step_evt;

            case (mode_q)
                M_STATIC: led_d = sel_pat;
                M_BLINK: begin
                    if (step_evt) led_d = (led_q == PAT_A) ? PAT_B : PAT_A;
                end
                M_RUN: begin
                    if (step_evt) led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                end
                M_BOUNCE: begin
                    // Reverse only after an end bit has been shown for a full step period
                    if (step_evt) begin
                        if (dir_up_q) begin
                            if (led_q[LED_W-1]) begin
                                led_d    = led_q >> 1;
                                dir_up_d = 1'b0;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                led_d    = led_q << 1;
                                dir_up_d = 1'b1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                end
                default: led_d = led_q;
            endcase
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios then random stimulus, all checked
// against an index/position based reference model of the animation rules.
module tb_led_pattern_gen;

    localparam int          W   = 4;
    localparam int          DIV = 4;
    localparam logic [3:0]  PA  = 4'b1010;
    localparam logic [3:0]  PB  = 4'b0101;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sel;
    logic [1:0] speed;
    logic [3:0] led;
    logic       tick;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [3:0] exp_led;
    logic       exp_tick;
    int         en_cnt;
    int         ticks;
    int         pos;
    int         dir;
    int         cur_mode;
    bit         show_a;

    led_pattern_gen #(
        .LED_W   (W),
        .CLK_DIV (DIV),
        .PAT_A   (PA),
        .PAT_B   (PB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .mode_i  (mode),
        .sel_i   (sel),
        .speed_i (speed),
        .led_o   (led),
        .tick_o  (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_step();
        bit step;
        step = 1'b0;
        if (rst) begin
            exp_led  = 4'b0000;
            exp_tick = 1'b0;
            en_cnt   = 0;
            ticks    = 0;
            dir      = 1;
            cur_mode = 0;
        end else if (int'(mode) != cur_mode) begin
            cur_mode = int'(mode);
            en_cnt   = 0;
            ticks    = 0;
            dir      = 1;
            pos      = 0;
            show_a   = 1'b1;
            exp_tick = 1'b0;
            if (cur_mode == 0)      exp_led = sel ? PA : PB;
            else if (cur_mode == 1) exp_led = PA;
            else                    exp_led = 4'b0001;
        end else begin
            if (en) begin
                if (en_cnt % DIV == DIV - 1) begin
                    ticks++;
                    if (ticks >= (1 << speed)) begin
                        step  = 1'b1;
                        ticks = 0;
                    end
                end
                en_cnt++;
            end
            exp_tick = step;
            if (step) begin
                case (cur_mode)
                    1: show_a = !show_a;
                    2: pos = (pos + 1) % W;
                    3: begin
                        if (pos == W - 1)  dir = -1;
                        else if (pos == 0) dir = 1;
                        pos = pos + dir;
                    end
                    default: ;
                endcase
            end
            case (cur_mode)
                0:       exp_led = sel ? PA : PB;
                1:       exp_led = show_a ? PA : PB;
                default: exp_led = 4'(1 << pos);
            endcase
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("model_led", led, exp_led);
        chk("model_tick", {3'b000, tick}, {3'b000, exp_tick});
    endtask

    logic [3:0] run_seq    [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] bounce_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                   4'b0010, 4'b0001, 4'b0010};

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'd0; sel = 1'b1; speed = 2'd0;
        exp_led = '0; exp_tick = 1'b0; en_cnt = 0; ticks = 0; pos = 0; dir = 1;
        cur_mode = 0; show_a = 1'b1;

        // Reset and STATIC select
        repeat (3) cycle();
        chk("rst_led", led, 4'b0000);
        chk("rst_tick", {3'b000, tick}, 4'b0000);
        rst = 1'b0;
        cycle();
        chk("static_a", led, PA);
        sel = 1'b0;
        cycle();
        chk("static_b", led, PB);

        // RUN at speed 0
        mode = 2'd2;
        cycle();
        chk("run_load", led, 4'b0001);
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (k % 4 == 3) begin
                chk("run_seq", led, run_seq[k / 4]);
                chk("run_tick", {3'b000, tick}, 4'b0001);
            end
        end

        // BOUNCE at speed 0
        mode = 2'd3;
        cycle();
        chk("bounce_load", led, 4'b0001);
        for (int k = 0; k < 28; k++) begin
            cycle();
            if (k % 4 == 3) chk("bounce_seq", led, bounce_seq[k / 4]);
        end

        // RUN frozen by en=0, then resumes after the remaining prescaler count
        mode = 2'd2;
        cycle();
        repeat (9) cycle();
        chk("run_pre_hold", led, 4'b0100);
        en = 1'b0;
        repeat (20) cycle();
        chk("run_hold", led, 4'b0100);
        en = 1'b1;
        repeat (3) cycle();
        chk("run_resume", led, 4'b1000);

        // BLINK at speed 2, then a speed drop mid-count
        mode = 2'd1; speed = 2'd2;
        cycle();
        chk("blink_load", led, PA);
        repeat (16) cycle();
        chk("blink_toggle", led, PB);
        repeat (6) cycle();
        speed = 2'd0;
        repeat (2) cycle();
        chk("blink_speed_drop", led, PA);

        // Mode change coincident with a base tick, then reset mid-run
        mode = 2'd3;
        cycle();
        repeat (12) cycle();
        chk("bounce_top", led, 4'b1000);
        repeat (3) cycle();
        mode = 2'd2;
        cycle();
        chk("chg_on_tick_led", led, 4'b0001);
        chk("chg_on_tick_tick", {3'b000, tick}, 4'b0000);
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        chk("rst_mid_run", led, 4'b0000);
        rst = 1'b0;

        // Random stimulus
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) speed = 2'($urandom_range(0, 3));
            if (en) begin
                if ($urandom_range(0, 31) == 0) en = 1'b0;
            end else begin
                if ($urandom_range(0, 7) == 0) en = 1'b1;
            end
            sel = 1'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter LED_W, default 10, number of LED outputs; legal range 2..32.
REQ-002 Parameter CLK_DIV, default 12_500_000, clk cycles per base tick; legal value >= 1.
REQ-003 Parameter PAT_A, default 10'b1001010111 (LED_W bits), primary static pattern.
REQ-004 Parameter PAT_B, default 10'b0110101000 (LED_W bits), secondary static pattern.
REQ-005 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en_i  input  1  animation enable; 0 freezes prescaler and stepping.
REQ-008 mode_i  input  2  0=STATIC, 1=BLINK, 2=RUN, 3=BOUNCE.
REQ-009 sel_i  input  1  STATIC mode pattern select: 1=PAT_A, 0=PAT_B.
REQ-010 speed_i  input  2  step period = CLK_DIV * 2^speed_i cycles.
REQ-011 led_o  output  LED_W  registered LED drive.
REQ-012 tick_o  output  1  one-cycle pulse on every step event.

Function
REQ-013 Prescaler counts 0..CLK_DIV-1 while en_i=1, wraps to 0; base tick asserted on the cycle count = CLK_DIV-1.
REQ-014 A 3-bit step counter increments on each base tick; step event fires on a base tick when step counter >= 2^speed_i - 1, and the step counter then clears to 0.
REQ-015 Reducing speed_i mid-count makes the next base tick fire a step immediately (>= compare); no lock-up.
REQ-016 en_i=0: prescaler, step counter, led_o (non-STATIC modes), and direction hold; tick_o=0.
REQ-017 tick_o asserted exactly in cycles where a step event fires; in STATIC mode tick_o still pulses.
REQ-018 Registered mode_q holds the previous mode_i; mode_i != mode_q is a mode change, processed in that cycle with priority over any step event.
REQ-019 Mode change: prescaler and step counter clear; RUN/BOUNCE load led_o=1 (bit 0) with direction up; BLINK loads led_o=PAT_A; STATIC loads per REQ-020.
REQ-020 STATIC: led_o <= sel_i ? PAT_A : PAT_B every cycle, 1-cycle latency, independent of en_i.
REQ-021 BLINK: each step toggles led_o between PAT_A and PAT_B (PAT_A -> PAT_B -> PAT_A ...).
REQ-022 RUN: each step rotates the one-hot led_o left by 1; bit LED_W-1 wraps to bit 0.
REQ-023 BOUNCE: up: shift left; on reaching bit LED_W-1 the next step shifts right and sets direction down; down: shift right; on reaching bit 0 the next step shifts left and sets direction up; end bits lit for exactly one step period each.
REQ-024 In RUN/BOUNCE led_o is always one-hot; no step produces all-zero.
REQ-025 Widths: prescaler is $clog2(CLK_DIV) bits (min 1); no truncation for any legal CLK_DIV.

Reset
REQ-026 rst=1 on a rising edge: led_o=0, tick_o=0, prescaler=0, step counter=0, direction=up, mode_q=0 (STATIC).
REQ-027 First cycle after reset release with mode_i!=0 is handled as a mode change (REQ-019); with mode_i=0 STATIC output appears one cycle later.
REQ-028 Reset asserted mid-animation overrides any step or mode change in the same cycle.

Verification (CLK_DIV=4, LED_W=4, PAT_A=4'b1010, PAT_B=4'b0101)
REQ-029 Reset, mode_i=0, sel_i=1 then 0 -> led_o=0 during reset, 1010 one cycle after release, 0101 one cycle after sel_i drops.
REQ-030 mode_i=2, en_i=1, speed_i=0 -> led_o 0001,0010,0100,1000,0001 changing every 4 cycles, tick_o one-cycle pulse per change.
REQ-031 mode_i=3, speed_i=0 -> 0001,0010,0100,1000,0100,0010,0001,0010; each state held 4 cycles.
REQ-032 mode_i=1, speed_i=2 -> 1010/0101 alternating every 16 cycles; drop speed_i to 0 at cycle 6 -> toggle at next base tick (cycle 8).
REQ-033 RUN at 0100, en_i=0 for 20 cycles -> led_o stays 0100, tick_o=0; en_i=1 -> next step after remaining prescaler count.
REQ-034 BOUNCE at 1000 moving down, switch mode_i 3->2 coincident with a base tick -> led_o=0001, counters cleared, no step that cycle; rst mid-run -> led_o=0 next cycle.
